// File: rtl/mmu_hs_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mmu_hs_pkg
//  Purpose  : Shared types for the MMU drive/free handshake merge point:
//             transaction FSM states and one-hot grant encodings.
//  Revision : 1.0  initial release
// ============================================================================
package mmu_hs_pkg;

  // Transaction phases of the merge point
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One-hot grant encodings, bit K = port K
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_P0   = 2'b01;
  localparam logic [1:0] GNT_P1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/rr_arb2_mmu.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2_mmu
//  Purpose  : Combinational 2-input round-robin picker. When both ports
//             request, the port named by i_ptr wins. The pointer itself is
//             owned and updated by the parent.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2_mmu
  import mmu_hs_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  // Pick the pointer port on contention, otherwise whichever port requests
  always_comb begin
    o_gnt = GNT_NONE;
    if (&i_req) begin
      o_gnt = i_ptr ? GNT_P1 : GNT_P0;
    end else if (i_req[0]) begin
      o_gnt = GNT_P0;
    end else if (i_req[1]) begin
      o_gnt = GNT_P1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/c_merger2_mmu.sv
`default_nettype none
// ============================================================================
//  Module   : c_merger2_mmu
//  Purpose  : 2-to-1 drive/free merge point. Two producers issue drive
//             pulses with payload; one is granted round-robin, forwarded
//             downstream as a single drive, and the downstream free is
//             routed back to the granted producer only.
//  Options  : MERGE_TIMEOUT_EN - builds a watchdog that releases a stuck
//             transaction after TIMEOUT_CYCLES without a downstream free.
//  Revision : 1.0  initial release
// ============================================================================
module c_merger2_mmu
  import mmu_hs_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_drive0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  output logic                  o_free0,
  input  logic                  i_drive1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_free1,
  output logic                  o_driveNext,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_sel,
  input  logic                  i_freeNext,
  output logic                  o_err,
  output logic                  o_timeout
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_pend;
  logic [1:0]            r_sel;
  logic                  r_ptr;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_hold0;
  logic [DATA_WIDTH-1:0] r_hold1;
  logic [DATA_WIDTH-1:0] r_data;

  logic [1:0]            w_drv;
  logic [1:0]            w_drv_err;
  logic [1:0]            w_drv_ok;
  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic [1:0]            w_pend_clr;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_free_spur;
  logic                  w_to_hit;

  // A drive is illegal while that port already waits or is being served;
  // the new pulse is dropped so the original request is kept intact.
  assign w_drv       = {i_drive1, i_drive0};
  assign w_drv_err   = w_drv & (r_pend | r_sel);
  assign w_drv_ok    = w_drv & ~w_drv_err;
  assign w_req       = r_pend | w_drv;
  assign w_pend_clr  = (r_state == ISSUE) ? r_sel : GNT_NONE;
  assign w_free_spur = i_freeNext & ((r_state == IDLE) | (r_state == DONE));

  // A same-cycle drive has not reached its hold register yet, so take it live
  assign w_gnt_data = w_gnt[1] ? (r_pend[1] ? r_hold1 : i_data1)
                               : (r_pend[0] ? r_hold0 : i_data0);

  rr_arb2_mmu u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

`ifdef MERGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Watchdog: zero while idle so it starts from 0 on entry to ISSUE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A free arriving in the limit cycle still completes normally
  assign w_to_hit = (r_state == WAIT) & ~i_freeNext & (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  // No watchdog: TIMEOUT_CYCLES has no effect, expression is constant 0
  assign w_to_hit = (TIMEOUT_CYCLES < 0);
`endif

  // Transaction state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant, issue one drive, wait for the free, return it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = i_freeNext ? DONE : WAIT;
      WAIT:    if (i_freeNext || w_to_hit) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, grant/payload registers, pointer and sticky error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend  <= GNT_NONE;
      r_sel   <= GNT_NONE;
      r_ptr   <= 1'b0;
      r_err   <= 1'b0;
      r_hold0 <= '0;
      r_hold1 <= '0;
      r_data  <= '0;
    end else begin
      r_pend <= (r_pend | w_drv_ok) & ~w_pend_clr;
      if (w_drv_ok[0]) r_hold0 <= i_data0;
      if (w_drv_ok[1]) r_hold1 <= i_data1;
      if ((r_state == IDLE) && (|w_req)) begin
        r_sel  <= w_gnt;
        r_data <= w_gnt_data;
      end else if (r_state == DONE) begin
        r_sel <= GNT_NONE;
        // Priority passes to the port that was not just served
        r_ptr <= r_sel[0];
      end
      r_err <= r_err | (|w_drv_err) | w_free_spur | w_to_hit;
    end
  end

  assign o_driveNext = (r_state == ISSUE);
  assign o_free0     = (r_state == DONE) & r_sel[0];
  assign o_free1     = (r_state == DONE) & r_sel[1];
  assign o_data      = r_data;
  assign o_sel       = r_sel;
  assign o_err       = r_err;
  assign o_timeout   = w_to_hit;

endmodule
`default_nettype wire

// File: tb/tb_c_merger2_mmu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c_merger2_mmu
//  Purpose  : Self-checking bench for c_merger2_mmu: directed vector table,
//             hand-written multi-cycle sequences and a randomized run
//             compared against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c_merger2_mmu;

  localparam int DW = 32;
  localparam int TO = 8;
`ifdef MERGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_drive0, i_drive1, i_freeNext;
  logic [DW-1:0] i_data0, i_data1;
  logic          o_free0, o_free1, o_driveNext, o_err, o_timeout;
  logic [DW-1:0] o_data;
  logic [1:0]    o_sel;

  c_merger2_mmu #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_drive0   (i_drive0),
    .i_data0    (i_data0),
    .o_free0    (o_free0),
    .i_drive1   (i_drive1),
    .i_data1    (i_data1),
    .o_free1    (o_free1),
    .o_driveNext(o_driveNext),
    .o_data     (o_data),
    .o_sel      (o_sel),
    .i_freeNext (i_freeNext),
    .o_err      (o_err),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          d0;
    logic [DW-1:0] x0;
    logic          d1;
    logic [DW-1:0] x1;
    logic          fn;
    logic          e_drv;
    logic          e_f0;
    logic          e_f1;
    logic [1:0]    e_sel;
    logic [DW-1:0] e_data;
    logic          e_err;
  } vec_t;

  vec_t tbl[8];

  // ---------------- sequence logging ----------------
  logic          auto_fn;
  logic          last_drv, last_f0, last_f1;
  logic [1:0]    isel_q[$];
  logic [DW-1:0] idat_q[$];
  int            nf0, nf1;

  task automatic clear_log();
    isel_q.delete();
    idat_q.delete();
    nf0 = 0; nf1 = 0;
    last_drv = 1'b0; last_f0 = 1'b0; last_f1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    i_drive0 = 1'b0; i_drive1 = 1'b0; i_freeNext = 1'b0;
    i_data0 = '0; i_data1 = '0;
    #1;
    chk("rst_drive", o_driveNext, 0);
    chk("rst_free", {o_free1, o_free0}, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_data", o_data, 0);
    chk("rst_err", o_err, 0);
    chk("rst_timeout", o_timeout, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One cycle of stimulus; optional automatic downstream responder
  task automatic cyc(input logic d0, input logic [DW-1:0] x0,
                     input logic d1, input logic [DW-1:0] x1, input logic fn);
    @(negedge clk);
    i_drive0 = d0; i_data0 = x0;
    i_drive1 = d1; i_data1 = x1;
    i_freeNext = fn | (auto_fn & last_drv);
    #1;
    last_drv = o_driveNext;
    last_f0  = o_free0;
    last_f1  = o_free1;
    if (o_driveNext) begin
      isel_q.push_back(o_sel);
      idat_q.push_back(o_data);
    end
    if (o_free0 || o_free1) begin
      nf0 += int'(o_free0);
      nf1 += int'(o_free1);
      chk("free_route", {o_free1, o_free0}, (isel_q.size() > 0) ? isel_q[$] : 2'b00);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_pend[2];
  logic [DW-1:0] m_pdata[2];
  int            m_ptr, m_g, m_age;
  bit            m_act, m_done, m_err;
  logic [DW-1:0] m_data;

  task automatic m_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_pdata[0] = '0; m_pdata[1] = '0;
    m_ptr = 0; m_g = 0; m_age = 0;
    m_act = 0; m_done = 0; m_err = 0;
    m_data = '0;
  endtask

  initial begin
    rstn = 1'b0;
    i_drive0 = 1'b0; i_drive1 = 1'b0; i_freeNext = 1'b0;
    i_data0 = '0; i_data1 = '0;
    auto_fn = 1'b0;
    clear_log();
    m_reset();

    // ---- single transaction and spurious free, table driven ----
    tbl[0] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         1'b0};
    tbl[2] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'hA5A5_0001, 1'b0};
    tbl[3] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'hA5A5_0001, 1'b0};
    tbl[4] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'hA5A5_0001, 1'b0};
    tbl[5] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 32'hA5A5_0001, 1'b0};
    tbl[6] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         1'b0};
    tbl[7] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         1'b1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_drive0 = tbl[i].d0; i_data0 = tbl[i].x0;
      i_drive1 = tbl[i].d1; i_data1 = tbl[i].x1;
      i_freeNext = tbl[i].fn;
      #1;
      chk($sformatf("tbl%0d_drive", i), o_driveNext, tbl[i].e_drv);
      chk($sformatf("tbl%0d_free0", i), o_free0, tbl[i].e_f0);
      chk($sformatf("tbl%0d_free1", i), o_free1, tbl[i].e_f1);
      chk($sformatf("tbl%0d_sel", i), o_sel, tbl[i].e_sel);
      if (tbl[i].e_sel != 2'b00) chk($sformatf("tbl%0d_data", i), o_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_err", i), o_err, tbl[i].e_err);
    end

    // ---- collision right after reset: port0 first, then port1 ----
    do_reset(); clear_log(); auto_fn = 1'b1;
    cyc(1'b1, 32'h0000_0011, 1'b1, 32'h0000_0022, 1'b0);
    for (int c = 0; c < 20; c++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("coll_issues", isel_q.size(), 2);
    if (isel_q.size() == 2) begin
      chk("coll_sel0", isel_q[0], 2'b01);
      chk("coll_sel1", isel_q[1], 2'b10);
      chk("coll_dat0", idat_q[0], 32'h0000_0011);
      chk("coll_dat1", idat_q[1], 32'h0000_0022);
    end
    chk("coll_nf0", nf0, 1);
    chk("coll_nf1", nf1, 1);
    chk("coll_err", o_err, 0);

    // ---- fairness: both ports re-request as soon as they are freed ----
    do_reset(); clear_log(); auto_fn = 1'b1;
    cyc(1'b1, $urandom, 1'b1, $urandom, 1'b0);
    for (int c = 0; c < 200 && isel_q.size() < 10; c++)
      cyc(last_f0, $urandom, last_f1, $urandom, 1'b0);
    chk("fair_issues", isel_q.size(), 10);
    for (int i = 0; i < isel_q.size(); i++)
      chk($sformatf("fair_gnt%0d", i), isel_q[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    chk("fair_err", o_err, 0);

    // ---- duplicate drive on a pending port: dropped, original kept ----
    do_reset(); clear_log(); auto_fn = 1'b1;
    cyc(1'b1, 32'h0000_00A0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h0000_00B1, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h0000_00B2, 1'b0);
    for (int c = 0; c < 15; c++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("dup_issues", isel_q.size(), 2);
    if (isel_q.size() == 2) begin
      chk("dup_sel1", isel_q[1], 2'b10);
      chk("dup_dat1", idat_q[1], 32'h0000_00B1);
    end
    chk("dup_nf1", nf1, 1);
    chk("dup_err", o_err, 1);

    // ---- asynchronous reset while waiting for the downstream free ----
    do_reset(); clear_log(); auto_fn = 1'b0;
    cyc(1'b1, 32'h0000_C0DE, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("arst_pre_sel", o_sel, 2'b01);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_drive", o_driveNext, 0);
    chk("arst_free", {o_free1, o_free0}, 0);
    chk("arst_sel", o_sel, 0);
    chk("arst_data", o_data, 0);
    chk("arst_err", o_err, 0);
    @(negedge clk);
    rstn = 1'b1;
    clear_log();
    for (int c = 0; c < 10; c++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    chk("arst_no_free", nf0 + nf1, 0);
    chk("arst_no_issue", isel_q.size(), 0);

`ifdef MERGE_TIMEOUT_EN
    // ---- watchdog: no downstream free at all ----
    do_reset(); clear_log(); auto_fn = 1'b0;
    cyc(1'b1, 32'h0000_7777, 1'b0, '0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b0);
      chk($sformatf("to_pulse_k%0d", k), o_timeout, (k == 9));
      chk($sformatf("to_free0_k%0d", k), o_free0, (k == 10));
    end
    chk("to_err", o_err, 1);
`endif

    // ---- randomized run against the reference model ----
    for (int ep = 0; ep < 4; ep++) begin
      int rate, spur;
      rate = (ep == 0) ? 8 : 15 + 5 * ep;
      spur = (ep == 0) ? 0 : 2;
      do_reset(); m_reset();
      for (int c = 0; c < 600; c++) begin
        logic          d[2];
        logic [DW-1:0] x[2];
        logic          fn, e_drv, e_to;
        logic [1:0]    e_sel;
        d[0] = ($urandom_range(0, 99) < rate);
        d[1] = ($urandom_range(0, 99) < rate);
        x[0] = $urandom;
        x[1] = $urandom;
        if (m_act && !m_done) fn = ($urandom_range(0, 99) < 30);
        else                  fn = ($urandom_range(0, 99) < spur);
        @(negedge clk);
        i_drive0 = d[0]; i_data0 = x[0];
        i_drive1 = d[1]; i_data1 = x[1];
        i_freeNext = fn;
        #1;
        e_drv = m_act && !m_done && (m_age == 0);
        e_to  = TO_EN && m_act && !m_done && (m_age == TO) && !fn;
        e_sel = !m_act ? 2'b00 : ((m_g == 0) ? 2'b01 : 2'b10);
        chk("rnd_drive", o_driveNext, e_drv);
        chk("rnd_free0", o_free0, m_act && m_done && (m_g == 0));
        chk("rnd_free1", o_free1, m_act && m_done && (m_g == 1));
        chk("rnd_sel", o_sel, e_sel);
        if (m_act) chk("rnd_data", o_data, m_data);
        chk("rnd_err", o_err, m_err);
        chk("rnd_timeout", o_timeout, e_to);
        // model update for this clock edge
        for (int k = 0; k < 2; k++) begin
          if (d[k]) begin
            if (m_pend[k] || (m_act && m_g == k)) m_err = 1;
            else begin m_pend[k] = 1; m_pdata[k] = x[k]; end
          end
        end
        if (fn && (!m_act || m_done)) m_err = 1;
        if (m_act) begin
          if (m_done) begin
            m_act = 0;
            m_ptr = 1 - m_g;
          end else if (fn) begin
            m_done = 1;
          end else if (e_to) begin
            m_done = 1;
            m_err  = 1;
          end else begin
            m_age++;
          end
        end else if (m_pend[0] || m_pend[1]) begin
          m_g = (m_pend[0] && m_pend[1]) ? m_ptr : (m_pend[0] ? 0 : 1);
          m_pend[m_g] = 0;
          m_data = m_pdata[m_g];
          m_act = 1; m_age = 0; m_done = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case anything above stalls
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
